mem_arbiter: RTL

Sequences a single variable-latency memory port shared by three requesters: beta instruction fetch (i), beta data access (d) and a DMA engine (x). Fixed priority d > i > x, with an aging counter that guarantees x eventually wins. Sits between the beta core/DMA and the memory; beta stalls on i_ack/d_ack.

---
 rtl/mem_arbiter.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory port between beta fetch (i),
// beta data (d) and DMA (x). Fixed priority d > i > x, with an aging counter
// so that a pending x request wins after AGE_MAX lost arbitrations.
// Optional build macro MEM_TIMEOUT_EN adds a BUSY-cycle abort after
// TIMEOUT_CYCLES without m_ack (ack pulses with err=1, reads return DEADBEEF).
//
// Handshake: a requester raises req with addr/we/wdata and holds them until
// it sees its one-cycle ack; the memory side holds m_req and m_* stable until
// m_ack is sampled high in BUSY. m_ack seen in IDLE or RESP is ignored.
module mem_arbiter #(
   parameter int unsigned AGE_MAX        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ack,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   input  logic        x_req,
   input  logic        x_we,
   input  logic [31:0] x_addr,
   input  logic [31:0] x_wdata,
   output logic [31:0] x_rdata,
   output logic        x_ack,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ack,
   output logic [1:0]  grant,
   output logic        err,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [1:0]  GR_NONE    = 2'd0;
   localparam logic [1:0]  GR_I       = 2'd1;
   localparam logic [1:0]  GR_D       = 2'd2;
   localparam logic [1:0]  GR_X       = 2'd3;
   localparam logic [3:0]  AGE_LIMIT  = 4'(AGE_MAX);
   localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

   state_e      state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic        m_req_q, m_req_d;
   logic        m_we_q, m_we_d;
   logic [31:0] m_addr_q, m_addr_d;
   logic [31:0] m_wdata_q, m_wdata_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic [31:0] x_rdata_q, x_rdata_d;
   logic        i_ack_q, i_ack_d;
   logic        d_ack_q, d_ack_d;
   logic        x_ack_q, x_ack_d;
   logic        err_q, err_d;
   logic [3:0]  age_q, age_d;
   logic [1:0]  winner;
   logic        tmo_hit;
   logic [31:0] resp_data;

`ifdef MEM_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo_q, tmo_d;

   // BUSY-cycle counter; held at zero outside BUSY so each transaction starts fresh
   always_comb begin
      tmo_d = '0;
      if (state_q == ST_BUSY) tmo_d = tmo_q + 16'd1;
   end

   // Timeout counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) tmo_q <= '0;
      else        tmo_q <= tmo_d;
   end

   assign tmo_hit = (tmo_q == TMO_LAST);
`else
   logic unused_tmo;
   assign unused_tmo = |32'(TIMEOUT_CYCLES);
   assign tmo_hit    = 1'b0;
`endif

   // Data returned to the winner: memory data, or the abort pattern on timeout
   assign resp_data = m_ack ? m_rdata : ABORT_DATA;

   // Arbitration: an aged x wins outright, otherwise d > i > x
   always_comb begin
      winner = GR_NONE;
      if (x_req && (age_q == AGE_LIMIT)) winner = GR_X;
      else if (d_req)                    winner = GR_D;
      else if (i_req)                    winner = GR_I;
      else if (x_req)                    winner = GR_X;
   end

   // Next-state and registered-output logic for IDLE -> BUSY -> RESP
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      m_req_d   = m_req_q;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      x_rdata_d = x_rdata_q;
      i_ack_d   = 1'b0;
      d_ack_d   = 1'b0;
      x_ack_d   = 1'b0;
      err_d     = 1'b0;
      age_d     = age_q;
      unique case (state_q)
         ST_IDLE: begin
            grant_d = GR_NONE;
            if (!x_req || (winner == GR_X)) age_d = '0;
            else if (age_q < AGE_LIMIT)     age_d = age_q + 4'd1;
            if (winner != GR_NONE) begin
               state_d = ST_BUSY;
               grant_d = winner;
               m_req_d = 1'b1;
               case (winner)
                  GR_I: begin
                     m_we_d    = 1'b0;
                     m_addr_d  = i_addr;
                     m_wdata_d = '0;
                  end
                  GR_D: begin
                     m_we_d    = d_we;
                     m_addr_d  = d_addr;
                     m_wdata_d = d_wdata;
                  end
                  default: begin
                     m_we_d    = x_we;
                     m_addr_d  = x_addr;
                     m_wdata_d = x_wdata;
                  end
               endcase
            end
         end
         ST_BUSY: begin
            // A real m_ack takes precedence over a coincident timeout
            if (m_ack || tmo_hit) begin
               state_d = ST_RESP;
               m_req_d = 1'b0;
               err_d   = !m_ack;
               case (grant_q)
                  GR_I: begin
                     i_ack_d = 1'b1;
                     if (!m_we_q) i_rdata_d = resp_data;
                  end
                  GR_D: begin
                     d_ack_d = 1'b1;
                     if (!m_we_q) d_rdata_d = resp_data;
                  end
                  default: begin
                     x_ack_d = 1'b1;
                     if (!m_we_q) x_rdata_d = resp_data;
                  end
               endcase
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            grant_d = GR_NONE;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = GR_NONE;
            m_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         grant_q   <= GR_NONE;
         m_req_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         x_rdata_q <= '0;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         x_ack_q   <= 1'b0;
         err_q     <= 1'b0;
         age_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         m_req_q   <= m_req_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         x_rdata_q <= x_rdata_d;
         i_ack_q   <= i_ack_d;
         d_ack_q   <= d_ack_d;
         x_ack_q   <= x_ack_d;
         err_q     <= err_d;
         age_q     <= age_d;
      end
   end

   assign i_rdata     = i_rdata_q;
   assign i_ack       = i_ack_q;
   assign d_rdata     = d_rdata_q;
   assign d_ack       = d_ack_q;
   assign x_rdata     = x_rdata_q;
   assign x_ack       = x_ack_q;
   assign m_req       = m_req_q;
   assign m_we        = m_we_q;
   assign m_addr      = m_addr_q;
   assign m_wdata     = m_wdata_q;
   assign grant       = grant_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule
